// File: rtl/pulse_sync_pkg.sv
// Shared constants and parameter helpers for the multi-channel toggle
// pulse receiver.
package pulse_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int CNT_W_MAX       = 16;

  // Number of events one channel can hold before further arrivals are dropped.
  function automatic int cnt_capacity(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  function automatic bit params_ok(input int ch, input int stages, input int cnt_w);
    return (ch >= 1) && (stages >= SYNC_STAGES_MIN) &&
           (cnt_w >= 1) && (cnt_w <= CNT_W_MAX);
  endfunction

endpackage

// File: rtl/pulse_sync_rx_ch.sv
// One receive channel: toggle synchroniser, edge detector, saturating
// pending-event counter and sticky overflow flag.
module pulse_sync_rx_ch
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgl,
  output logic             pulse,
  output logic             valid,
  input  logic             ready,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_capacity(CNT_W));

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;
  logic last;
  logic inc;
  logic pop;
  logic full;

  // Both terms are flops, so the pulse cannot glitch on a tgl change.
  assign pulse = sync[SYNC_STAGES-1] ^ last;
  assign valid = (cnt != '0);
  assign inc   = pulse;
  assign pop   = valid & ready;
  assign full  = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      last <= 1'b0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tgl};
      last <= sync[SYNC_STAGES-1];

      // A simultaneous arrival and pop leaves the count alone, even when full.
      if (inc && !pop && !full) begin
        cnt <= cnt + 1'b1;
      end else if (!inc && pop) begin
        cnt <= cnt - 1'b1;
      end

      // A drop in the same cycle as a clear request keeps the flag set.
      if (inc && !pop && full) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pulse_sync_rx.sv
// Destination-side receiver for CH toggle-encoded event streams; each channel
// is independent and the top level only slices the buses.
module pulse_sync_rx
  import pulse_sync_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       tgl_in,
  output logic [CH-1:0]       pulse_out,
  output logic [CH-1:0]       evt_valid,
  input  logic [CH-1:0]       evt_ready,
  output logic [CH*CNT_W-1:0] evt_cnt,
  output logic [CH-1:0]       ovf,
  input  logic [CH-1:0]       ovf_clr
);

  if (!params_ok(CH, SYNC_STAGES, CNT_W)) begin : g_param_check
    $error("pulse_sync_rx: illegal CH/SYNC_STAGES/CNT_W combination");
  end

  // Handshake: per channel, one event leaves at every rising edge where
  // evt_valid and evt_ready are both high; evt_valid never depends on
  // evt_ready, and evt_ready is ignored while evt_valid is low.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    pulse_sync_rx_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tgl    (tgl_in[i]),
      .pulse  (pulse_out[i]),
      .valid  (evt_valid[i]),
      .ready  (evt_ready[i]),
      .cnt    (evt_cnt[i*CNT_W +: CNT_W]),
      .ovf    (ovf[i]),
      .ovf_clr(ovf_clr[i])
    );
  end

endmodule

// File: tb/tb_pulse_sync_rx.sv
// Bench for pulse_sync_rx: directed scenarios followed by random traffic,
// all checked every cycle against an event-schedule reference model.
module tb_pulse_sync_rx;

  localparam int CH          = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 3;
  localparam int CAP         = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [CH-1:0]       tgl_in;
  logic [CH-1:0]       pulse_out;
  logic [CH-1:0]       evt_valid;
  logic [CH-1:0]       evt_ready;
  logic [CH*CNT_W-1:0] evt_cnt;
  logic [CH-1:0]       ovf;
  logic [CH-1:0]       ovf_clr;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  // Reference model: exp_q holds, per channel, the edge numbers after which
  // a pulse is due; counts follow the pending-event arithmetic directly.
  int exp_q[CH][$];
  int cnt_m[CH];
  bit ovf_m[CH];
  bit pulse_m[CH];
  bit ref_lvl[CH];
  int last_flip[CH];

  pulse_sync_rx #(
    .CH         (CH),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tgl_in   (tgl_in),
    .pulse_out(pulse_out),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_cnt  (evt_cnt),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    return 32'(evt_cnt[i*CNT_W +: CNT_W]);
  endfunction

  // ---------------- reference model ----------------
  task automatic model_edge();
    int nxt;
    edge_no++;
    for (int i = 0; i < CH; i++) begin
      if (rst) begin
        cnt_m[i]   = 0;
        ovf_m[i]   = 1'b0;
        pulse_m[i] = 1'b0;
        ref_lvl[i] = 1'b0;
        exp_q[i].delete();
      end else begin
        nxt = cnt_m[i] + int'(pulse_m[i]) - int'((cnt_m[i] != 0) && evt_ready[i]);
        if (nxt > CAP) begin
          ovf_m[i] = 1'b1;
          nxt = CAP;
        end else if (ovf_clr[i]) begin
          ovf_m[i] = 1'b0;
        end
        cnt_m[i] = nxt;
        if (tgl_in[i] != ref_lvl[i]) begin
          exp_q[i].push_back(edge_no + SYNC_STAGES - 1);
          ref_lvl[i] = tgl_in[i];
        end
        pulse_m[i] = 1'b0;
        if (exp_q[i].size() > 0 && exp_q[i][0] == edge_no) begin
          pulse_m[i] = 1'b1;
          void'(exp_q[i].pop_front());
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < CH; i++) begin
      check($sformatf("pulse[%0d]@%0d", i, edge_no), 32'(pulse_out[i]), 32'(pulse_m[i]));
      check($sformatf("valid[%0d]@%0d", i, edge_no), 32'(evt_valid[i]), 32'(cnt_m[i] != 0));
      check($sformatf("cnt[%0d]@%0d", i, edge_no), cnt_of(i), 32'(cnt_m[i]));
      check($sformatf("ovf[%0d]@%0d", i, edge_no), 32'(ovf[i]), 32'(ovf_m[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic flip(input int i);
    tgl_in[i] = ~tgl_in[i];
    last_flip[i] = edge_no + 1;
  endtask

  task automatic release_rst();
    rst = 1'b0;
    for (int i = 0; i < CH; i++) last_flip[i] = edge_no + 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    tgl_in    = '0;
    evt_ready = '0;
    ovf_clr   = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_m[i] = 0; ovf_m[i] = 0; pulse_m[i] = 0; ref_lvl[i] = 0; last_flip[i] = 0;
    end

    repeat (2) tick();
    check("rst_pulse", 32'(pulse_out), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_cnt", 32'(evt_cnt), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    release_rst();
    repeat (3) tick();

    // Single toggle on ch0: pulse two edges after the change, count one later.
    flip(0);
    tick();
    check("single_pulse_early", 32'(pulse_out[0]), 32'd0);
    tick();
    check("single_pulse", 32'(pulse_out[0]), 32'd1);
    check("single_valid_early", 32'(evt_valid[0]), 32'd0);
    tick();
    check("single_pulse_end", 32'(pulse_out[0]), 32'd0);
    check("single_valid", 32'(evt_valid[0]), 32'd1);
    check("single_cnt", cnt_of(0), 32'd1);
    evt_ready[0] = 1'b1;
    tick();
    evt_ready[0] = 1'b0;
    check("single_pop_cnt", cnt_of(0), 32'd0);
    check("single_pop_valid", 32'(evt_valid[0]), 32'd0);

    // Stalled burst on ch2 saturates and flags overflow.
    for (int n = 0; n < 9; n++) begin
      flip(2);
      repeat (3) tick();
    end
    check("burst_sat_cnt", cnt_of(2), 32'd7);
    check("burst_ovf", 32'(ovf[2]), 32'd1);
    evt_ready[2] = 1'b1;
    repeat (7) tick();
    evt_ready[2] = 1'b0;
    check("burst_drain_valid", 32'(evt_valid[2]), 32'd0);
    check("burst_ovf_kept", 32'(ovf[2]), 32'd1);
    ovf_clr[2] = 1'b1;
    tick();
    ovf_clr[2] = 1'b0;
    check("burst_ovf_clr", 32'(ovf[2]), 32'd0);

    // ch1 full, then an arrival and a pop at the same edge.
    for (int n = 0; n < 7; n++) begin
      flip(1);
      repeat (3) tick();
    end
    check("full_cnt", cnt_of(1), 32'd7);
    flip(1);
    repeat (2) tick();
    evt_ready[1] = 1'b1;
    tick();
    evt_ready[1] = 1'b0;
    check("incpop_cnt", cnt_of(1), 32'd7);
    check("incpop_ovf", 32'(ovf[1]), 32'd0);
    evt_ready[1] = 1'b1;
    repeat (7) tick();
    evt_ready[1] = 1'b0;
    check("incpop_drain", cnt_of(1), 32'd0);

    // Simultaneous toggles on ch0/ch3, consumer only on ch3.
    evt_ready[3] = 1'b1;
    flip(0);
    flip(3);
    repeat (3) tick();
    check("indep_cnt0_a", cnt_of(0), 32'd1);
    check("indep_cnt3_a", cnt_of(3), 32'd1);
    tick();
    check("indep_cnt3_b", cnt_of(3), 32'd0);
    check("indep_cnt0_b", cnt_of(0), 32'd1);
    check("indep_cnt1", cnt_of(1), 32'd0);
    check("indep_cnt2", cnt_of(2), 32'd0);
    evt_ready[3] = 1'b0;
    evt_ready[0] = 1'b1;
    tick();
    evt_ready[0] = 1'b0;

    // Reset mid-operation with ch0 at 5 and overflowed; ch1 goes high in reset.
    for (int n = 0; n < 8; n++) begin
      flip(0);
      repeat (3) tick();
    end
    evt_ready[0] = 1'b1;
    repeat (2) tick();
    evt_ready[0] = 1'b0;
    check("pre_rst_cnt0", cnt_of(0), 32'd5);
    check("pre_rst_ovf0", 32'(ovf[0]), 32'd1);
    rst = 1'b1;
    flip(1);
    tick();
    check("mid_rst_pulse", 32'(pulse_out), 32'd0);
    check("mid_rst_valid", 32'(evt_valid), 32'd0);
    check("mid_rst_cnt", 32'(evt_cnt), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    release_rst();
    repeat (3) tick();
    check("held_high_cnt1", cnt_of(1), 32'd1);
    repeat (5) tick();
    check("held_high_once", cnt_of(1), 32'd1);
    check("held_low_cnt0", cnt_of(0), 32'd0);
    evt_ready = '1;
    repeat (2) tick();
    evt_ready = '0;

    // Random traffic: legal toggle spacing, random consumer, rare clears/resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ((edge_no + 1 - last_flip[i] >= SYNC_STAGES + 1) && ($urandom_range(0, 2) == 0))
          flip(i);
        evt_ready[i] = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
        ovf_clr[i]   = ($urandom_range(0, 15) == 0);
      end
      if (rst) release_rst();
      else if ($urandom_range(0, 149) == 0) rst = 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
